// File: rtl/stepdown_pkg.sv
// Shared types and default timing constants for the step-down converter blocks.
package stepdown_pkg;

    typedef enum logic [1:0] {OFF, SS, RUN, FAULT} corestate_t;

    localparam int SS_W_DEF      = 6;
    localparam int SS_DIV_DEF    = 16;
    localparam int UV_DEG_DEF    = 8;
    localparam int OCP_DEG_DEF   = 4;
    localparam int PG_DEG_DEF    = 8;
    localparam int RETRY_CYC_DEF = 1024;

endpackage

// File: rtl/stepdown_deglitch.sv
// Saturating N-consecutive-high filter. hit is combinational: it flags the
// sample that completes the run, so the consumer can act on that same edge.
module stepdown_deglitch #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic din,
    output logic hit
);

    localparam int W = $clog2(N + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (clr || !din)
            cnt <= '0;
        else if (cnt != W'(N))
            cnt <= cnt + 1'b1;
    end

    assign hit = din && (cnt >= W'(N - 1));

endmodule

// File: rtl/stepdown_corestate_seq.sv
// Step-down core state sequencer: UVLO/enable handshake, soft-start ramp,
// OCP hiccup retry and pgood deglitch, driving core_state to the buffer chain.
module stepdown_corestate_seq
    import stepdown_pkg::*;
#(
    parameter int SS_W      = SS_W_DEF,
    parameter int SS_DIV    = SS_DIV_DEF,
    parameter int UV_DEG    = UV_DEG_DEF,
    parameter int OCP_DEG   = OCP_DEG_DEF,
    parameter int PG_DEG    = PG_DEG_DEF,
    parameter int RETRY_CYC = RETRY_CYC_DEF
) (
    input  logic            CELCLK,
    input  logic            CELRST,
    input  logic            CELV,
    input  logic            CELG,
    input  logic            SUB,
    input  logic            en,
    input  logic            uvlo_ok,
    input  logic            ocp,
    input  logic            pgood_cmp,
    output logic            core_state,
    output logic [SS_W-1:0] ss_code,
    output logic            pgood,
    output logic            fault
);

    localparam int PW = $clog2(SS_DIV);
    localparam int RW = $clog2(RETRY_CYC + 1);
    localparam logic [SS_W-1:0] SS_MAX = '1;

    // Supply/substrate pins exist for the netlist only.
    logic unused_pins;
    assign unused_pins = CELV ^ CELG ^ SUB;

    corestate_t     state, state_n;
    logic [PW-1:0]  pre, pre_n;
    logic [RW-1:0]  retry, retry_n;
    logic [SS_W-1:0] ss_n;
    logic           core_n, pgood_n, fault_n;
    logic           uv_hit, ocp_hit, pg_hit;
    logic           wrap, active, active_n;

    // Counters are held clear on any edge that leaves their state, so every
    // re-entry starts a fresh count.
    stepdown_deglitch #(.N(UV_DEG)) u_uv (
        .clk(CELCLK), .rst(CELRST),
        .clr((state != OFF) || (state_n != OFF)),
        .din(uvlo_ok), .hit(uv_hit)
    );

    stepdown_deglitch #(.N(OCP_DEG)) u_ocp (
        .clk(CELCLK), .rst(CELRST),
        .clr(!active || !active_n),
        .din(ocp), .hit(ocp_hit)
    );

    stepdown_deglitch #(.N(PG_DEG)) u_pg (
        .clk(CELCLK), .rst(CELRST),
        .clr((state != RUN) || (state_n != RUN)),
        .din(pgood_cmp), .hit(pg_hit)
    );

    assign wrap     = (pre == PW'(SS_DIV - 1));
    assign active   = (state == SS) || (state == RUN);
    assign active_n = (state_n == SS) || (state_n == RUN);

    always_comb begin
        state_n = state;
        case (state)
            OFF:     if (en && uv_hit) state_n = SS;
            SS:      if (ocp_hit) state_n = FAULT;
                     else if (wrap && ss_code == SS_MAX - 1'b1) state_n = RUN;
            RUN:     if (ocp_hit) state_n = FAULT;
            FAULT:   if (retry == RW'(RETRY_CYC - 1)) state_n = OFF;
            default: state_n = OFF;
        endcase
        if (!uvlo_ok || !en)
            state_n = OFF;

        pre_n = '0;
        if (state == SS && state_n == SS)
            pre_n = wrap ? '0 : pre + 1'b1;

        retry_n = '0;
        if (state == FAULT && state_n == FAULT)
            retry_n = (retry == RW'(RETRY_CYC - 1)) ? retry : retry + 1'b1;

        case (state_n)
            SS:      ss_n = (state == SS && wrap) ? ss_code + 1'b1 : ss_code;
            RUN:     ss_n = SS_MAX;
            default: ss_n = '0;
        endcase

        core_n  = active_n;
        fault_n = (state_n == FAULT);
        pgood_n = (state == RUN) && (state_n == RUN) && pg_hit;
    end

    always_ff @(posedge CELCLK) begin
        if (CELRST) begin
            state      <= OFF;
            pre        <= '0;
            retry      <= '0;
            ss_code    <= '0;
            core_state <= 1'b0;
            pgood      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= state_n;
            pre        <= pre_n;
            retry      <= retry_n;
            ss_code    <= ss_n;
            core_state <= core_n;
            pgood      <= pgood_n;
            fault      <= fault_n;
        end
    end

endmodule

// File: tb/tb_stepdown_corestate_seq.sv
// Directed bench for the step-down core state sequencer at default parameters.
module tb_stepdown_corestate_seq;

    logic       CELCLK = 1'b0;
    logic       CELRST, CELV, CELG, SUB;
    logic       en, uvlo_ok, ocp, pgood_cmp;
    logic       core_state, pgood, fault;
    logic [5:0] ss_code;

    int checks   = 0;
    int failures = 0;

    stepdown_corestate_seq dut (
        .CELCLK(CELCLK), .CELRST(CELRST), .CELV(CELV), .CELG(CELG), .SUB(SUB),
        .en(en), .uvlo_ok(uvlo_ok), .ocp(ocp), .pgood_cmp(pgood_cmp),
        .core_state(core_state), .ss_code(ss_code), .pgood(pgood), .fault(fault)
    );

    always #5 CELCLK = ~CELCLK;

    // Inputs change just after a falling edge; outputs are read there too.
    task automatic tick(input int n);
        repeat (n) @(negedge CELCLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // {core_state, fault, pgood, ss_code}
    task automatic chk_all(input string tag, input logic c, input logic f,
                           input logic p, input logic [5:0] s);
        chk(tag, {23'd0, core_state, fault, pgood, ss_code}, {23'd0, c, f, p, s});
    endtask

    initial begin
        CELRST = 1'b1; CELV = 1'b1; CELG = 1'b0; SUB = 1'b0;
        en = 1'b0; uvlo_ok = 1'b0; ocp = 1'b0; pgood_cmp = 1'b0;
        tick(3);
        chk_all("reset", 0, 0, 0, 0);

        // 1) start-up handshake and ramp
        en = 1'b1; uvlo_ok = 1'b1; CELRST = 1'b0;
        tick(7);  chk_all("uv_deg_7", 0, 0, 0, 0);
        tick(1);  chk_all("ss_entry", 1, 0, 0, 0);
        tick(15); chk_all("ss_pre_15", 1, 0, 0, 0);
        tick(1);  chk_all("ss_code_1", 1, 0, 0, 1);
        tick(991); chk_all("ss_1007", 1, 0, 0, 62);
        tick(1);  chk_all("run_entry", 1, 0, 0, 63);

        // 2) pgood deglitch
        pgood_cmp = 1'b1;
        tick(7);  chk_all("pg_7", 1, 0, 0, 63);
        tick(1);  chk_all("pg_8", 1, 0, 1, 63);
        pgood_cmp = 1'b0;
        tick(1);  chk_all("pg_drop", 1, 0, 0, 63);
        pgood_cmp = 1'b1;
        tick(7);  chk_all("pg_re7", 1, 0, 0, 63);
        tick(1);  chk_all("pg_re8", 1, 0, 1, 63);

        // 3) OCP: 3 samples ignored, 4 trips, hiccup retry
        ocp = 1'b1; tick(3); ocp = 1'b0;
        tick(1);  chk_all("ocp_3_ignored", 1, 0, 1, 63);
        ocp = 1'b1;
        tick(3);  chk_all("ocp_3_of_4", 1, 0, 1, 63);
        tick(1);  chk_all("ocp_trip", 0, 1, 0, 0);
        ocp = 1'b0;
        tick(1023); chk_all("retry_1023", 0, 1, 0, 0);
        tick(1);  chk_all("retry_exit", 0, 0, 0, 0);
        tick(7);  chk_all("restart_uv_7", 0, 0, 0, 0);
        tick(1);  chk_all("restart_ss", 1, 0, 0, 0);

        // 4) uvlo glitch mid-ramp
        tick(320); chk_all("ss_code_20", 1, 0, 0, 20);
        uvlo_ok = 1'b0;
        tick(1);  chk_all("uvlo_abort", 0, 0, 0, 0);
        uvlo_ok = 1'b1;
        tick(7);  chk_all("uvlo_re7", 0, 0, 0, 0);
        tick(1);  chk_all("uvlo_re_ss", 1, 0, 0, 0);

        // 5) OCP trip coincides with ramp completion
        tick(1004); chk_all("ss_1004", 1, 0, 0, 62);
        ocp = 1'b1;
        tick(3);  chk_all("ss_1007_ocp", 1, 0, 0, 62);
        tick(1);  chk_all("fault_beats_run", 0, 1, 0, 0);
        ocp = 1'b0;
        tick(5);  chk_all("fault_hold", 0, 1, 0, 0);
        en = 1'b0;
        tick(1);  chk_all("en_drop_fault", 0, 0, 0, 0);
        tick(20); chk_all("en_low_off", 0, 0, 0, 0);
        // uvlo_ok stayed high throughout OFF, so the handshake is already met
        en = 1'b1;
        tick(1);  chk_all("en_restart_ss", 1, 0, 0, 0);

        // 6) reset while in RUN with pgood high
        tick(1008); chk_all("run_again", 1, 0, 0, 63);
        tick(8);  chk_all("pg_again", 1, 0, 1, 63);
        CELRST = 1'b1;
        tick(1);  chk_all("mid_reset", 0, 0, 0, 0);
        tick(2);  chk_all("reset_hold", 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
